// File: rtl/sram_image_loader_pkg.sv
// +--------------------------------------------------------------------------+
// | img_pkg : shared image geometry, pixel type and loader state encoding     |
// | Rev 1.0  - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package img_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int NPIX   = IMG_W * IMG_H;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    START,
    WAIT_OUT
  } loader_state_t;

  typedef logic [DATA_W-1:0] pix_t;

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// +--------------------------------------------------------------------------+
// | raster_counter : clearable enabled pixel counter, tc flags NPIX-1         |
// | Rev 1.0  - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module raster_counter #(
  parameter int CNT_W = img_pkg::ADDR_W + 1,
  parameter int NPIX  = img_pkg::NPIX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(NPIX - 1));

endmodule

`default_nettype wire

// File: rtl/sram_image_loader.sv
// +--------------------------------------------------------------------------+
// | sram_image_loader : streams a raster frame into the image SRAM, kicks    |
// | the filter and counts its output beats. Option: LOADER_CHECKSUM_EN.       |
// | Rev 1.0  - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module sram_image_loader #(
  parameter int ADDR_W = img_pkg::ADDR_W,
  parameter int DATA_W = img_pkg::DATA_W,
  parameter int IMG_W  = img_pkg::IMG_W,
  parameter int IMG_H  = img_pkg::IMG_H
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              sram_en,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_d,
  output logic              sram_grant,
  output logic              start,
  input  logic              out_valid,
  output logic              busy,
  output logic              frame_done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  import img_pkg::*;

  localparam int C_NPIX  = IMG_W * IMG_H;
  localparam int C_CNT_W = ADDR_W + 1;

  loader_state_t      r_state;
  loader_state_t      w_next;
  logic [C_CNT_W-1:0] w_wr_cnt;
  logic [C_CNT_W-1:0] w_rd_cnt;
  logic               w_wr_tc;
  logic               w_rd_tc;
  logic               w_wr_clr;
  logic               w_rd_clr;
  logic               w_hs;
  logic               w_rd_en;
  logic               w_unused;

  assign w_hs     = (r_state == LOAD) && in_valid && in_ready;
  assign w_rd_en  = (r_state == WAIT_OUT) && out_valid;
  assign w_unused = ^{w_rd_cnt, w_wr_cnt[ADDR_W]};

  raster_counter #(.CNT_W(C_CNT_W), .NPIX(C_NPIX)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_wr_clr),
    .en    (w_hs),
    .cnt   (w_wr_cnt),
    .tc    (w_wr_tc)
  );

  raster_counter #(.CNT_W(C_CNT_W), .NPIX(C_NPIX)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_rd_clr),
    .en    (w_rd_en),
    .cnt   (w_rd_cnt),
    .tc    (w_rd_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_wr_clr = 1'b0;
    w_rd_clr = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_req) begin
          w_next   = LOAD;
          w_wr_clr = 1'b1;
        end
      end
      LOAD:     if (w_hs && w_wr_tc) w_next = FLUSH;
      FLUSH:    w_next = START;
      START: begin
        w_next   = WAIT_OUT;
        w_rd_clr = 1'b1;
      end
      WAIT_OUT: if (w_rd_en && w_rd_tc) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so in_ready drops in the
  // same cycle the FSM leaves LOAD; start is delayed one beat past START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      sram_en    <= 1'b0;
      sram_wen   <= 1'b0;
      sram_addr  <= '0;
      sram_d     <= '0;
      sram_grant <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      in_ready   <= (w_next == LOAD);
      sram_en    <= w_hs;
      sram_wen   <= w_hs;
      if (w_hs) begin
        sram_addr <= w_wr_cnt[ADDR_W-1:0];
        sram_d    <= in_pixel;
      end
      sram_grant <= (w_next == LOAD) || (w_next == FLUSH);
      start      <= (r_state == START);
      busy       <= (w_next != IDLE);
      frame_done <= w_rd_en && w_rd_tc;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (w_wr_clr) begin
      checksum <= '0;
    end else if (w_hs) begin
      checksum <= checksum + 16'(in_pixel);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_image_loader.sv
// +--------------------------------------------------------------------------+
// | tb_sram_image_loader : randomized bench for sram_image_loader (4x4 frame) |
// | Rev 1.0  - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sram_image_loader;

  localparam int NPIX  = 16;
  localparam int NEVER = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        sram_en;
  logic        sram_wen;
  logic [15:0] sram_addr;
  logic [7:0]  sram_d;
  logic        sram_grant;
  logic        start;
  logic        out_valid;
  logic        busy;
  logic        frame_done;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  sram_image_loader #(
    .ADDR_W (16),
    .DATA_W (8),
    .IMG_W  (4),
    .IMG_H  (4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_d     (sram_d),
    .sram_grant (sram_grant),
    .start      (start),
    .out_valid  (out_valid),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  typedef struct packed {
    int         c;
    logic [7:0] pix;
  } wr_t;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          cyc      = 0;
  int          phase    = 0;   // 0 idle, 1 loading until start, 2 collecting output
  int          m_hs     = 0;
  int          m_addr   = 0;
  int          n_out    = 0;
  int          exp_start_at = NEVER;
  int          exp_fd_at    = -1;
  logic [15:0] m_sum    = '0;
  logic        m_rdy    = 1'b0;
  wr_t         pend_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs();
    return {1'b0, in_ready, sram_en, sram_wen, sram_grant, start, busy, frame_done,
            sram_addr, sram_d};
  endfunction

  // Reference model: consumes the inputs about to be sampled by the next edge.
  task automatic drive_model();
    if (load_req && phase == 0) begin
      phase = 1; m_hs = 0; m_addr = 0; m_sum = '0; n_out = 0; exp_start_at = NEVER;
    end
    if (in_valid && m_rdy) begin
      pend_q.push_back('{c: cyc, pix: in_pixel});
      m_sum = m_sum + 16'(in_pixel);
      m_hs++;
      if (m_hs == NPIX) exp_start_at = cyc + 3;
    end
    if (out_valid && phase == 2) begin
      n_out++;
      if (n_out == NPIX) begin
        phase     = 0;
        exp_fd_at = cyc + 1;
      end
    end
  endtask

  task automatic observe();
    logic exp_w;
    logic exp_rdy;
    wr_t  w;
    exp_w = (pend_q.size() > 0) && (pend_q[0].c + 1 == cyc);
    check("sram_en", sram_en, exp_w);
    check("sram_wen", sram_wen, exp_w);
    if (exp_w) begin
      w = pend_q.pop_front();
      check("sram_addr", sram_addr, m_addr);
      check("sram_d", sram_d, w.pix);
      m_addr++;
    end
    check("sram_grant", sram_grant, (phase == 1) && (cyc <= exp_start_at - 2));
    check("start", start, cyc == exp_start_at);
    check("frame_done", frame_done, cyc == exp_fd_at);
    if (cyc != exp_fd_at) check("busy", busy, phase != 0);
    exp_rdy = (phase == 1) && (m_hs < NPIX);
    check("in_ready", in_ready, exp_rdy);
`ifdef LOADER_CHECKSUM_EN
    if (exp_rdy && !m_rdy) check("cks_clear", checksum, 0);
    if (cyc == exp_start_at || phase == 2) check("cks_hold", checksum, m_sum);
`endif
    m_rdy = exp_rdy;
    if (cyc == exp_start_at) phase = 2;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  // vmode: 0 hold valid, 1 toggle, 2 random. pmode: 0 0x10+i, 1 0xFF, 2 random.
  task automatic run_frame(input int vmode, input int pmode, input bit coincide);
    int g;
    g = 0;
    load_req = 1'b1; in_valid = 1'b0; out_valid = 1'b0;
    drive_model(); tick();
    load_req = 1'b0;
    while (phase != 0 && g < 2000) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (g % 2 == 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      case (pmode)
        0:       in_pixel = 8'h10 + 8'(m_hs);
        1:       in_pixel = 8'hFF;
        default: in_pixel = 8'($urandom);
      endcase
      if (phase == 2 && vmode == 0) out_valid = 1'b1;
      else                          out_valid = ($urandom_range(0, 2) != 0);
      load_req = ($urandom_range(0, 7) == 0);
      if (coincide && phase == 2 && n_out == NPIX - 1) begin
        out_valid = 1'b1;
        load_req  = 1'b1;
      end
      drive_model(); tick();
      g++;
    end
    check("frame_timeout", g < 2000, 1);
    in_valid = 1'b0; out_valid = 1'b0; load_req = 1'b0;
    repeat (2) begin
      drive_model(); tick();
    end
    check("pend_empty", pend_q.size(), 0);
  endtask

  task automatic reset_mid_load();
    int g;
    g = 0;
    load_req = 1'b1; in_valid = 1'b0; out_valid = 1'b0;
    drive_model(); tick();
    load_req = 1'b0;
    while (m_hs < 7 && g < 100) begin
      in_valid = 1'b1;
      in_pixel = 8'($urandom);
      drive_model(); tick();
      g++;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst", outs(), 0);
`ifdef LOADER_CHECKSUM_EN
    check("async_rst_cks", checksum, 0);
`endif
    phase = 0; m_rdy = 1'b0; m_hs = 0; exp_start_at = NEVER;
    pend_q.delete();
    repeat (2) begin
      drive_model(); tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_pixel = '0; out_valid = 1'b0;
    #3 check("reset_outs", outs(), 0);
    repeat (2) begin
      drive_model(); tick();
    end
    rst_n = 1'b1;
    // in_valid / out_valid while idle must not cause activity
    in_valid = 1'b1; out_valid = 1'b1; in_pixel = 8'hAA;
    drive_model(); tick();
    in_valid = 1'b0; out_valid = 1'b0;
    drive_model(); tick();

    run_frame(0, 0, 1'b0);
    run_frame(1, 0, 1'b0);
    run_frame(2, 2, 1'b1);
    run_frame(0, 1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("cks_ff", checksum, 16'h0FF0);
`endif
    run_frame(2, 2, 1'b0);
    reset_mid_load();
    run_frame(0, 0, 1'b0);
    for (int r = 0; r < 4; r++) run_frame(2, 2, r[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire
